pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 12 +
 rtl/pong_score_ctr.sv | 31 +++
 rtl/pong_game_ctrl.sv | 93 +++++++++
 tb/tb_pong_game_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, BCD digit width and default game parameters.
package pong_pkg;
  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;
  localparam int BCD_W            = 4;
  localparam int DEF_WIN_SCORE    = 11;
  localparam int DEF_DELAY_FRAMES = 120;
endpackage

// File: rtl/pong_score_ctr.sv
// pong_score_ctr: one player's score as a binary count and a BCD pair, plus a flag
// telling the sequencer that the next increment reaches WIN_SCORE.
module pong_score_ctr
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = DEF_WIN_SCORE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               inc,
  output logic [2*BCD_W-1:0] bcd,
  output logic               win
);
  logic [6:0]       bin;
  logic [BCD_W-1:0] ones, tens;
  assign ones = bcd[BCD_W-1:0];
  assign tens = bcd[2*BCD_W-1:BCD_W];
  assign win  = bin == 7'(WIN_SCORE - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bin <= '0;
      bcd <= '0;
    end else if (clr) begin
      bin <= '0;
      bcd <= '0;
    end else if (inc) begin
      bin <= bin + 7'd1;
      bcd <= (ones == 4'd9) ? {(tens == 4'd9) ? tens : tens + 4'd1, 4'd0} : {tens, ones + 4'd1};
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game sequencer, frame-timed serve/game-over pauses and BCD scores.
// Optional SERVE_DIR_EN builds a serve-direction register; otherwise serve_dir is 0.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int DELAY_FRAMES = DEF_DELAY_FRAMES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       refresh_tick,
  input  logic [3:0] btn,
  input  logic       pts_1,
  input  logic       pts_2,
  output logic       gra_still,
  output logic [1:0] game_state,
  output logic [7:0] score1_bcd,
  output logic [7:0] score2_bcd,
  output logic       game_over,
  output logic       winner,
  output logic       serve_dir
);
  state_t     state;
  logic [6:0] timer;
  logic       btn_any, btn_any_q, armed;
  logic       start, clr, inc1, inc2, win1, win2;
  // armed stays low until all buttons are seen released, so a press held through reset cannot start
  assign start      = btn_any & ~btn_any_q & armed;
  assign clr        = state == ST_NEWGAME && start;
  assign inc1       = state == ST_PLAY && pts_1;
  assign inc2       = state == ST_PLAY && !pts_1 && pts_2;
  assign game_state = state;
  pong_score_ctr #(.WIN_SCORE(WIN_SCORE)) u_s1 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .inc(inc1), .bcd(score1_bcd), .win(win1)
  );
  pong_score_ctr #(.WIN_SCORE(WIN_SCORE)) u_s2 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .inc(inc2), .bcd(score2_bcd), .win(win2)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= ST_NEWGAME;
      gra_still <= 1'b1;
      game_over <= 1'b0;
      winner    <= 1'b0;
      timer     <= '0;
      btn_any   <= 1'b0;
      btn_any_q <= 1'b0;
      armed     <= 1'b0;
    end else begin
      btn_any   <= |btn;
      btn_any_q <= btn_any;
      armed     <= armed | ~(|btn);
      if ((state == ST_NEWBALL || state == ST_OVER) && refresh_tick && timer != 7'd0)
        timer <= timer - 7'd1;
      case (state)
        ST_NEWGAME: if (start) begin
          state     <= ST_PLAY;
          gra_still <= 1'b0;
          winner    <= 1'b0;
        end
        ST_PLAY: if (pts_1 || pts_2) begin
          timer     <= 7'(DELAY_FRAMES);
          gra_still <= 1'b1;
          if (pts_1 ? win1 : win2) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
            winner    <= !pts_1;
          end else
            state <= ST_NEWBALL;
        end
        ST_NEWBALL: if (timer == 7'd0) begin
          state     <= ST_PLAY;
          gra_still <= 1'b0;
        end
        ST_OVER: if (timer == 7'd0) begin
          state     <= ST_NEWGAME;
          game_over <= 1'b0;
        end
      endcase
    end
`ifdef SERVE_DIR_EN
  // serve toward the player who just conceded
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      serve_dir <= 1'b0;
    else if (clr)
      serve_dir <= 1'b0;
    else if (inc1 || inc2)
      serve_dir <= inc1;
`else
  assign serve_dir = 1'b0;
`endif
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed test of pong_game_ctrl; dut_a uses WIN_SCORE=3, dut_b WIN_SCORE=12.
module tb_pong_game_ctrl;
  logic       clk = 1'b0;
  logic       rst_a, rst_b, refresh_tick, pts_1, pts_2;
  logic [3:0] btn;
  logic       still_a, over_a, win_a, sd_a, still_b, over_b, win_b, sd_b;
  logic [1:0] st_a, st_b;
  logic [7:0] s1_a, s2_a, s1_b, s2_b;
  int         n_tests = 0, n_fail = 0;
`ifdef SERVE_DIR_EN
  localparam logic SD = 1'b1;
`else
  localparam logic SD = 1'b0;
`endif
  always #5 clk = ~clk;
  pong_game_ctrl #(.WIN_SCORE(3), .DELAY_FRAMES(4)) dut_a (
    .clk(clk), .reset_n(rst_a), .refresh_tick(refresh_tick), .btn(btn), .pts_1(pts_1), .pts_2(pts_2),
    .gra_still(still_a), .game_state(st_a), .score1_bcd(s1_a), .score2_bcd(s2_a),
    .game_over(over_a), .winner(win_a), .serve_dir(sd_a)
  );
  pong_game_ctrl #(.WIN_SCORE(12), .DELAY_FRAMES(4)) dut_b (
    .clk(clk), .reset_n(rst_b), .refresh_tick(refresh_tick), .btn(btn), .pts_1(pts_1), .pts_2(pts_2),
    .gra_still(still_b), .game_state(st_b), .score1_bcd(s1_b), .score2_bcd(s2_b),
    .game_over(over_b), .winner(win_b), .serve_dir(sd_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      refresh_tick = 1'b1;
      cyc(1);
      refresh_tick = 1'b0;
      cyc(1);
    end
  endtask
  task automatic point(input logic p1, input logic p2);
    pts_1 = p1;
    pts_2 = p2;
    cyc(1);
    pts_1 = 1'b0;
    pts_2 = 1'b0;
    cyc(1);
  endtask
  initial begin
    rst_a = 1'b0; rst_b = 1'b0; refresh_tick = 1'b0; pts_1 = 1'b0; pts_2 = 1'b0; btn = 4'b0001;
    cyc(3);
    check("rst_state", st_a, 2'b00);
    check("rst_still", still_a, 1'b1);
    check("rst_scores", {s1_a, s2_a}, 16'h0000);
    check("rst_over_win_sd", {over_a, win_a, sd_a}, 3'b000);
    // held button through reset must not start
    rst_a = 1'b1;
    cyc(5);
    check("held_no_start", st_a, 2'b00);
    btn = 4'b0000;
    cyc(2);
    btn = 4'b0100;
    cyc(1);
    check("edge_not_yet", st_a, 2'b00);
    cyc(1);
    check("start_play", st_a, 2'b01);
    check("start_still", still_a, 1'b0);
    check("start_scores", {s1_a, s2_a}, 16'h0000);
    btn = 4'b0000;
    // level pts_1 held 10 clocks gives one point
    pts_1 = 1'b1;
    cyc(10);
    pts_1 = 1'b0;
    check("p1_once", s1_a, 8'h01);
    check("p1_newball", st_a, 2'b10);
    check("p1_still", still_a, 1'b1);
    check("p1_serve", sd_a, SD);
    frames(3);
    check("nb_3ticks", st_a, 2'b10);
    frames(1);
    check("nb_back_play", st_a, 2'b01);
    check("nb_play_still", still_a, 1'b0);
    // simultaneous points: pts_1 wins priority
    point(1'b1, 1'b1);
    check("both_s1", s1_a, 8'h02);
    check("both_s2", s2_a, 8'h00);
    frames(4);
    for (int i = 0; i < 3; i++) begin
      point(1'b0, 1'b1);
      if (i < 2) begin
        check("p2_newball", st_a, 2'b10);
        check("p2_serve", sd_a, 1'b0);
        frames(4);
      end
    end
    check("over_state", st_a, 2'b11);
    check("over_flags", {over_a, win_a, still_a}, 3'b111);
    check("over_s2", s2_a, 8'h03);
    frames(4);
    check("after_over_state", st_a, 2'b00);
    check("after_over_hold", {over_a, win_a, s2_a}, {2'b01, 8'h03});
    btn = 4'b1000;
    cyc(2);
    check("restart_play", st_a, 2'b01);
    check("restart_clear", {win_a, s1_a, s2_a}, 17'h0);
    btn = 4'b0000;
    // async reset mid-countdown
    point(1'b1, 1'b0);
    check("serve_p1", sd_a, SD);
    frames(2);
    check("mid_newball", st_a, 2'b10);
    #2 rst_a = 1'b0;
    #1;
    check("async_state", st_a, 2'b00);
    check("async_still", still_a, 1'b1);
    check("async_scores", {s1_a, s2_a}, 16'h0000);
    check("async_flags", {over_a, win_a, sd_a}, 3'b000);
    cyc(1);
    // BCD tens carry on dut_b
    rst_b = 1'b1;
    cyc(2);
    btn = 4'b0001;
    cyc(2);
    btn = 4'b0000;
    check("b_play", st_b, 2'b01);
    for (int i = 1; i <= 10; i++) begin
      point(1'b1, 1'b0);
      if (i == 9) check("b_bcd9", s1_b, 8'h09);
      frames(4);
    end
    check("b_bcd10", s1_b, 8'h10);
    check("b_bin10", dut_b.u_s1.bin, 7'd10);
    check("b_not_over", {st_b, over_b}, 3'b010);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
